// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: PC, single-outstanding imem reads,
//            prefetch FIFO feeding decode. Optional halt-on-opcode-1111
//            feature enabled by the FETCH_HALT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              instr_valid,
  output logic [15:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_WAIT = 2'd1;
  localparam logic [1:0] C_ST_DROP = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_CNT_W-1:0] count_q, count_d;
  logic [15:0]        data_q [DEPTH];
  logic [ADDR_W-1:0]  pcs_q  [DEPTH];

  logic w_halted;
  logic w_issue;
  logic w_push;
  logic w_pop;

  // A request only issues when a FIFO slot is free, so an ack never meets a full FIFO.
  assign w_issue = (state_q == C_ST_IDLE) && (count_q < C_DEPTH) && !w_halted && !redirect;
  assign w_push  = (state_q == C_ST_WAIT) && imem_ack && !redirect;
  assign w_pop   = (count_q != '0) && instr_ready && !redirect;

`ifdef FETCH_HALT_EN
  logic halt_q, halt_d;

  always_comb begin
    halt_d = halt_q;
    if (redirect) begin
      halt_d = 1'b0;
    end else if (w_push && (imem_rdata[15:10] == 6'b00_1111)) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign w_halted = halt_q;
`else
  assign w_halted = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE: begin
        if (w_issue) begin
          state_d = C_ST_WAIT;
        end
      end
      C_ST_WAIT: begin
        if (imem_ack) begin
          state_d = C_ST_IDLE;
        end else if (redirect) begin
          state_d = C_ST_DROP;
        end
      end
      C_ST_DROP: begin
        if (imem_ack) begin
          state_d = C_ST_IDLE;
        end
      end
      default: state_d = C_ST_IDLE;
    endcase
  end

  // In WAIT/DROP the address is the latched one, so a redirect cannot disturb it.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      C_ST_IDLE: begin
        imem_req = w_issue;
      end
      C_ST_WAIT, C_ST_DROP: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
    if (rst) begin
      imem_req = 1'b0;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    addr_d   = addr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (w_issue) begin
      addr_d = pc_q;
    end
    if (redirect) begin
      pc_d     = redirect_addr;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        pc_d     = pc_q + ADDR_W'(1);
        wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + C_CNT_W'(1);
        2'b01:   count_d = count_q - C_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (w_push) begin
        data_q[wr_ptr_q] <= imem_rdata;
        pcs_q[wr_ptr_q]  <= addr_q;
      end
    end
  end

  assign instr_valid = (count_q != '0);
  assign instr_data  = data_q[rd_ptr_q];
  assign instr_pc    = pcs_q[rd_ptr_q];

endmodule

`default_nettype wire
